// File: rtl/mxn_pkg.sv
// Shared definitions for the MxN parallel-in/serial-out unloader:
// control state encoding, counter sizing helper and frame slicing offset.
package mxn_pkg;

    // Control state: IDLE holds no frame, SHIFT presents word cnt of a held frame.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Ceiling log2 with a floor of 1, so a single-word frame still gets a
    // one-bit counter rather than a zero-width vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Bit offset of word i inside a frame of m-bit words (word 0 is the LSBs).
    function automatic int word_lsb(input int m, input int i);
        return m * i;
    endfunction

endpackage

// File: rtl/dffn_en.sv
// W-bit register with synchronous active-high reset and load enable.
module dffn_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset clears the word; otherwise capture d only when enabled.
    always_ff @(posedge clk) begin
        if (srst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mxn_piso.sv
// mxn_piso: accepts one N-word frame of M-bit words in parallel and drains it
// one word per output handshake. A new frame may be accepted on the same edge
// the last word of the current frame leaves, so back-to-back frames stream
// without an idle cycle. All outputs come from registers except load_ready.
module mxn_piso
    import mxn_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [M*N-1:0] load_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_data,
    output logic           out_last
);

    localparam int            CW      = clog2_min1(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    state_e          state_reg;
    state_e          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;

    logic [M-1:0]    frame_q [N];
    logic [M-1:0]    word_next;
    logic [M-1:0]    out_d;
    logic            out_en;

    logic            at_last;
    logic            load_fire;
    logic            xfer;

    // Handshake decode. out_valid/out_last decode only registered state, so
    // nothing on the input side reaches them combinationally.
    assign at_last    = (cnt_reg == CNT_MAX);
    assign out_valid  = (state_reg == SHIFT);
    assign out_last   = out_valid & at_last;
    assign xfer       = out_valid & out_ready;
    assign load_ready = (state_reg == IDLE) | (xfer & at_last);
    assign load_fire  = load_valid & load_ready;

    // Frame store: one enabled register per word, written only when a load fires.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_frame
            dffn_en #(.W(M)) u_word (
                .clk  (clk),
                .srst (rst),
                .en   (load_fire),
                .d    (load_data[word_lsb(M, gi) +: M]),
                .q    (frame_q[gi])
            );
        end
    endgenerate

    // Select the word following cnt; only consulted while cnt is below N-1.
    always_comb begin
        word_next = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (cnt_reg == CW'(i)) begin
                word_next = frame_q[i + 1];
            end
        end
    end

    // Output word source: word 0 comes straight from load_data because the
    // frame store is being written on that same edge.
    always_comb begin
        out_en = load_fire | (xfer & ~at_last);
        out_d  = load_fire ? load_data[M-1:0] : word_next;
    end

    dffn_en #(.W(M)) u_out (
        .clk  (clk),
        .srst (rst),
        .en   (out_en),
        .d    (out_d),
        .q    (out_data)
    );

    // Next state and word index: a load restarts at word 0, a transfer advances
    // until the last word, after which the block goes idle unless reloaded.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (load_fire) begin
            state_next = SHIFT;
            cnt_next   = '0;
        end else if (xfer) begin
            if (at_last) begin
                state_next = IDLE;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Control registers; reset wins over any simultaneous load or transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mxn_piso.sv
// Bench for mxn_piso: one instance with M=3,N=4 and one with M=8,N=1.
// Expected words are queued when a load is driven and compared as the DUT
// hands words out; per-cycle flags are checked by the stimulus itself.
module tb_mxn_piso;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // M=3, N=4 instance
    logic        lv0 = 1'b0;
    logic        lr0;
    logic [11:0] ld0 = '0;
    logic        ov0;
    logic        or0 = 1'b0;
    logic [2:0]  od0;
    logic        ol0;

    // M=8, N=1 instance
    logic        lv1 = 1'b0;
    logic        lr1;
    logic [7:0]  ld1 = '0;
    logic        ov1;
    logic        or1 = 1'b0;
    logic [7:0]  od1;
    logic        ol1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb0[$];
    logic [31:0] sb1[$];

    mxn_piso #(.M(3), .N(4)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv0),
        .load_ready (lr0),
        .load_data  (ld0),
        .out_valid  (ov0),
        .out_ready  (or0),
        .out_data   (od0),
        .out_last   (ol0)
    );

    mxn_piso #(.M(8), .N(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv1),
        .load_ready (lr1),
        .load_data  (ld1),
        .out_valid  (ov1),
        .out_ready  (or1),
        .out_data   (od1),
        .out_last   (ol1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the four 3-bit words of a frame, word 0 first; last flag in bit 8.
    task automatic push0(input logic [11:0] f);
        logic [2:0] w;
        for (int i = 0; i < 4; i++) begin
            w = f[3*i +: 3];
            sb0.push_back({23'd0, (i == 3), 5'd0, w});
        end
    endtask

    // Scoreboard compare for the M=3,N=4 instance on each real transfer.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && ov0 && or0) begin
            check("w0_expected", 32'(sb0.size() != 0), 32'd1);
            if (sb0.size() != 0) begin
                e = sb0.pop_front();
                check("w0_data", {29'd0, od0}, {29'd0, e[2:0]});
                check("w0_last", {31'd0, ol0}, {31'd0, e[8]});
            end
        end
    end

    // Scoreboard compare for the M=8,N=1 instance.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && ov1 && or1) begin
            check("w1_expected", 32'(sb1.size() != 0), 32'd1);
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                check("w1_data", {24'd0, od1}, {24'd0, e[7:0]});
                check("w1_last", {31'd0, ol1}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset for two cycles, then check the idle state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid",  {31'd0, ov0}, 32'd0);
        check("rst_out_data",   {29'd0, od0}, 32'd0);
        check("rst_out_last",   {31'd0, ol0}, 32'd0);
        check("rst_load_ready", {31'd0, lr0}, 32'd1);

        // Basic frame with the consumer always ready.
        or0 = 1'b1;
        lv0 = 1'b1;
        ld0 = 12'hF51;
        push0(12'hF51);
        tick();
        lv0 = 1'b0;
        ld0 = 12'hFFF;
        for (int i = 0; i < 4; i++) begin
            check("basic_valid", {31'd0, ov0}, 32'd1);
            tick();
        end
        check("basic_idle_after", {31'd0, ov0}, 32'd0);

        // Backpressure while word 1 is presented.
        lv0 = 1'b1;
        ld0 = 12'hF51;
        push0(12'hF51);
        tick();
        lv0 = 1'b0;
        tick();
        or0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_data",       {29'd0, od0}, 32'd2);
            check("bp_cnt",        {30'd0, dut0.cnt_reg}, 32'd1);
            check("bp_load_ready", {31'd0, lr0}, 32'd0);
            check("bp_last",       {31'd0, ol0}, 32'd0);
            tick();
        end
        or0 = 1'b1;
        tick();
        tick();
        tick();
        check("bp_idle_after", {31'd0, ov0}, 32'd0);

        // Back-to-back frames with load_valid held high.
        lv0 = 1'b1;
        ld0 = 12'hF51;
        push0(12'hF51);
        tick();
        ld0 = 12'h0A3;
        push0(12'h0A3);
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid_a",    {31'd0, ov0}, 32'd1);
            check("b2b_load_ready", {31'd0, lr0}, 32'(i == 3));
            tick();
        end
        lv0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid_b", {31'd0, ov0}, 32'd1);
            tick();
        end
        check("b2b_idle_after", {31'd0, ov0}, 32'd0);

        // Reset while word 2 is presented; remaining words are discarded.
        lv0 = 1'b1;
        ld0 = 12'hF51;
        push0(12'hF51);
        tick();
        lv0 = 1'b0;
        tick();
        tick();
        check("mid_pre_data", {29'd0, od0}, 32'd5);
        rst = 1'b1;
        sb0.delete();
        tick();
        rst = 1'b0;
        check("mid_out_valid",  {31'd0, ov0}, 32'd0);
        check("mid_out_data",   {29'd0, od0}, 32'd0);
        check("mid_out_last",   {31'd0, ol0}, 32'd0);
        check("mid_load_ready", {31'd0, lr0}, 32'd1);
        lv0 = 1'b1;
        ld0 = 12'h0A3;
        push0(12'h0A3);
        tick();
        lv0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mid_reload_valid", {31'd0, ov0}, 32'd1);
            tick();
        end
        check("mid_idle_after", {31'd0, ov0}, 32'd0);

        // Single-word frames, M=8: A5 then 3C with no gap.
        or1 = 1'b1;
        lv1 = 1'b1;
        ld1 = 8'hA5;
        sb1.push_back({23'd0, 1'b1, 8'hA5});
        tick();
        ld1 = 8'h3C;
        sb1.push_back({23'd0, 1'b1, 8'h3C});
        check("n1_valid_a",      {31'd0, ov1}, 32'd1);
        check("n1_last_a",       {31'd0, ol1}, 32'd1);
        check("n1_load_ready_a", {31'd0, lr1}, 32'd1);
        tick();
        lv1 = 1'b0;
        check("n1_valid_b", {31'd0, ov1}, 32'd1);
        check("n1_last_b",  {31'd0, ol1}, 32'd1);
        tick();
        check("n1_idle_after", {31'd0, ov1}, 32'd0);

        // Every queued word must have been delivered.
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
